// File: rtl/pc_fetch.sv
// Instruction fetch: PC register plus IF/ID pipeline register; optional perf counter under FETCH_PERF_CNT_EN.
// Latency: one cycle from pc to IF/ID; every output is registered.
// Backpressure: stall holds pc and IF/ID; flush overrides stall, reloads pc and inserts a bubble.
module pc_fetch #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  new_address,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_data,
  output logic [7:0]  pc,
  output logic [7:0]  ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic {RUN, HOLD} mode_e;

  mode_e mode;
  logic  fetch_vld;

  // Only stall without flush holds the stage; flush always reloads.
  always_comb begin
    mode = RUN;
    if (stall && !flush) mode = HOLD;
    fetch_vld = (mode == RUN) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      ifid_pc    <= 8'h00;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (mode == RUN) begin
      pc         <= new_address;
      ifid_pc    <= pc;
      ifid_instr <= fetch_vld ? imem_data : NOP_INSTR;
      ifid_valid <= fetch_vld;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      fetch_count <= 16'h0000;
    else if (fetch_vld && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed plus randomized checks of pc_fetch against a cycle-level reference model.
module tb_pc_fetch;
  localparam logic [7:0]  RST_PC = 8'h00;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  new_address = 8'h00;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] imem_data;
  logic [7:0]  pc;
  logic [7:0]  ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [7:0]  m_pc = RST_PC;
  logic [7:0]  m_ifid_pc = 8'h00;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  // instruction memory model: word at address a is A000_0000 + a
  assign imem_data = 32'hA000_0000 + {24'h0, pc};

  pc_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .new_address(new_address),
    .stall(stall),
    .flush(flush),
    .imem_data(imem_data),
    .pc(pc),
    .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, {24'h0, pc}, {24'h0, m_pc});
    chk({tag, ".ifid_pc"}, {24'h0, ifid_pc}, {24'h0, m_ifid_pc});
    chk({tag, ".ifid_instr"}, ifid_instr, m_instr);
    chk({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".fetch_count"}, {16'h0, fetch_count}, m_cnt);
`endif
  endtask

  // One clock: apply inputs, advance the model by the stage rules, then compare.
  task automatic step(input string tag, input logic rst_n, input logic [7:0] na,
                      input logic st, input logic fl);
    reset_n = rst_n;
    new_address = na;
    stall = st;
    flush = fl;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RST_PC; m_ifid_pc = 8'h00; m_instr = NOP; m_valid = 1'b0; m_cnt = 0;
    end else if (fl) begin
      m_ifid_pc = m_pc; m_instr = NOP; m_valid = 1'b0; m_pc = na;
    end else if (!st) begin
      m_ifid_pc = m_pc; m_instr = 32'hA000_0000 + m_pc; m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      m_pc = na;
    end
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b1, m_pc + 8'h01, 1'b0, 1'b0);
  endtask

  initial begin
    // reset held two cycles
    step("reset0", 1'b0, 8'h00, 1'b0, 1'b0);
    step("reset1", 1'b0, 8'h00, 1'b1, 1'b1);
    // release: IF/ID captures the instruction at RESET_PC
    seq("release");
    chk("release.first_instr", ifid_instr, 32'hA000_0000);
    while (m_pc != 8'h05) seq("run");
    // stall three cycles at pc 0x05
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 8'h77, 1'b1, 1'b0);
    chk("stall.held_pc", {24'h0, ifid_pc}, 32'h04);
    seq("stall_release");
    chk("stall_release.ifid_pc", {24'h0, ifid_pc}, 32'h05);
    // flush at pc 0x06 redirecting to 0x20
    step("flush", 1'b1, 8'h20, 1'b0, 1'b1);
    chk("flush.pc", {24'h0, pc}, 32'h20);
    seq("after_flush");
    chk("after_flush.ifid_pc", {24'h0, ifid_pc}, 32'h20);
    // stall and flush together: flush wins
    step("stall_flush", 1'b1, 8'h40, 1'b1, 1'b1);
    chk("stall_flush.valid", {31'h0, ifid_valid}, 32'h0);
    // wrap from 0xFE
    step("to_fe", 1'b1, 8'hFE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) seq("wrap");
    chk("wrap.pc", {24'h0, pc}, 32'h01);
    chk("wrap.ifid_pc", {24'h0, ifid_pc}, 32'h00);
    // reset asserted mid-stall and mid-flush
    step("mid_stall", 1'b1, 8'h10, 1'b1, 1'b0);
    step("rst_stall", 1'b0, 8'h10, 1'b1, 1'b0);
    step("rst_flush", 1'b0, 8'h33, 1'b0, 1'b1);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r, s, f;
      r = ($urandom_range(0, 99) >= 3);
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 15);
      step("rand", r, 8'($urandom_range(0, 255)), s, f);
    end
`ifdef FETCH_PERF_CNT_EN
    step("cnt_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) seq("cnt_fill");
    chk("cnt.sat", {16'h0, fetch_count}, 32'h0000_FFFF);
    seq("cnt_hold");
    chk("cnt.hold", {16'h0, fetch_count}, 32'h0000_FFFF);
    step("cnt_mid_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("cnt.cleared", {16'h0, fetch_count}, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, giving the instruction word inserted as a bubble.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port new_address, input, 8 bits: next-PC from the branch stage (target or PC+1).
REQ-006 The block SHALL have port stall, input, 1 bit: hazard hold request.
REQ-007 The block SHALL have port flush, input, 1 bit: taken branch/jump, so the fetched instruction is squashed.
REQ-008 The block SHALL have port imem_data, input, 32 bits: instruction memory read data, combinational from pc.
REQ-009 The block SHALL have port pc, output, 8 bits: current PC; drives the instruction memory address and the branch stage instruction_address.
REQ-010 The block SHALL have port ifid_pc, output, 8 bits: IF/ID register, PC of the held instruction.
REQ-011 The block SHALL have port ifid_instr, output, 32 bits: IF/ID register, held instruction.
REQ-012 The block SHALL have port ifid_valid, output, 1 bit: IF/ID holds a real (non-bubble) instruction.
REQ-013 The block SHALL have port fetch_count, output, 16 bits: retired-fetch counter (present only per REQ-026).

Function
REQ-014 The PC SHALL be a register; it loads new_address every cycle unless stall=1 and flush=0.
REQ-015 The PC SHALL hold its value when stall=1 and flush=0.
REQ-016 The IF/ID register SHALL capture {pc, imem_data, valid=1} when stall=0 and flush=0, giving one-cycle fetch latency.
REQ-017 When flush=1, the IF/ID register SHALL load {ifid_pc=pc, ifid_instr=NOP_INSTR, ifid_valid=0}, regardless of stall.
REQ-018 When stall=1 and flush=0, the IF/ID register SHALL hold all fields unchanged.
REQ-019 When stall=1 and flush=1 occur together, flush SHALL win: the PC loads new_address and IF/ID takes a bubble.
REQ-020 The block SHALL perform no arithmetic on the PC; 8'hFF to 8'h00 wrap-around is inherited unchanged from new_address.
REQ-021 The block SHALL insert no combinational path from stall, flush or new_address to any output; all outputs are registered.
REQ-022 The block SHALL have exactly two effective states per cycle, RUN (load) and HOLD (stall without flush), selected by stall and flush only; no other FSM is permitted.

Reset
REQ-023 When reset_n=0 at a rising edge of clk, the block SHALL set pc=RESET_PC, ifid_pc=8'h00, ifid_instr=NOP_INSTR, ifid_valid=0 and fetch_count=0.
REQ-024 Reset SHALL take priority over stall and flush, including when asserted mid-stall or mid-flush.
REQ-025 On the first edge after reset_n returns to 1 with stall=0 and flush=0, IF/ID SHALL capture the instruction at RESET_PC with valid=1.

Configuration
REQ-026 With macro FETCH_PERF_CNT_EN defined, fetch_count SHALL exist and increment by 1 on each edge where IF/ID loads with valid=1 (stall=0, flush=0), saturating at 16'hFFFF.
REQ-027 With FETCH_PERF_CNT_EN undefined, the fetch_count port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset test: hold reset_n=0 for 2 cycles, then release with new_address=pc+1 and imem_data=32'hA000_0000+pc -> pc=0 after reset; ifid_valid=0 then 1; ifid_pc=0x00 and ifid_instr=32'hA000_0000 one cycle after release.
REQ-029 Stall test: at pc=0x05 assert stall for 3 cycles -> pc stays 0x05 and IF/ID stays at instruction 0x04 for 3 cycles; fetch_count does not change; on release, IF/ID gets 0x05.
REQ-030 Flush test: at pc=0x06 drive new_address=0x20 with flush=1 -> next cycle pc=0x20, ifid_valid=0, ifid_instr=NOP_INSTR; following cycle ifid_pc=0x20 with valid=1.
REQ-031 Simultaneous test: stall=1, flush=1, new_address=0x40 -> pc=0x40 and bubble in IF/ID.
REQ-032 Wrap test: run sequential fetch from pc=0xFE -> pc goes 0xFE, 0xFF, 0x00; ifid_pc follows one cycle later.
REQ-033 Counter test (FETCH_PERF_CNT_EN): preload via 70000 valid fetches -> fetch_count=16'hFFFF and holds; a reset mid-run clears it to 0.
